// File: rtl/spi_peripheral.sv
// SPI peripheral, CPHA=0 with selectable CPOL, oversampled in the i_clk domain.
// A one-byte holding register feeds the TX shifter at each byte boundary.
module spi_peripheral #(
  parameter logic CPOL = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk,
  input  logic       i_cs_n,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_tx_underrun,
  output logic       o_busy
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t r_state;

  logic r_sclk_s1;
  logic r_sclk_s2;
  logic r_sclk_s3;
  logic r_cs_s1;
  logic r_cs_s2;
  logic r_cs_s3;
  logic r_mosi_s1;
  logic r_mosi_s2;

  logic [1:0] r_fill;
  logic       r_armed;

  logic [6:0] r_rx_shift;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic [2:0] r_bit_cnt;
  logic       r_byte_done;

  logic [7:0] r_tx_shift;
  logic [7:0] r_hold;
  logic       r_hold_full;
  logic       r_underrun;

  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_lead;
  logic       w_trail;
  logic       w_cs_fall;
  logic       w_cs_rise;
  logic       w_active;
  logic       w_start;
  logic       w_abort;
  logic       w_shift_out;
  logic       w_reload;
  logic       w_load;
  logic       w_wr;
  logic [7:0] w_rx_byte;

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
  assign w_lead      = CPOL ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = CPOL ? w_sclk_rise : w_sclk_fall;
  assign w_cs_fall   = ~r_cs_s2 & r_cs_s3;
  assign w_cs_rise   = r_cs_s2 & ~r_cs_s3;

  assign w_active    = (r_state == S_ACTIVE);
  assign w_start     = ~w_active & w_cs_fall & r_armed;
  assign w_abort     = w_active & w_cs_rise;
  assign w_shift_out = w_active & ~w_cs_rise & w_trail;
  assign w_reload    = w_shift_out & (r_bit_cnt == 3'd0) & r_byte_done;
  assign w_load      = w_start | w_reload;
  assign w_wr        = i_tx_valid & ~r_hold_full;
  assign w_rx_byte   = {r_rx_shift, r_mosi_s2};

  // CS_N is only trusted once a genuine high level has passed the
  // synchronizer, so a frame already running at reset release is skipped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclk_s1 <= CPOL;
      r_sclk_s2 <= CPOL;
      r_sclk_s3 <= CPOL;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_s3   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_fill    <= 2'd0;
      r_armed   <= 1'b0;
    end else begin
      r_sclk_s1 <= i_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_cs_s1   <= i_cs_n;
      r_cs_s2   <= r_cs_s1;
      r_cs_s3   <= r_cs_s2;
      r_mosi_s1 <= i_mosi;
      r_mosi_s2 <= r_mosi_s1;
      if (r_fill != 2'd2)
        r_fill <= r_fill + 2'd1;
      if (r_fill == 2'd2 && r_cs_s2)
        r_armed <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd0;
      r_rx_shift  <= 7'd0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_byte_done <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state     <= S_ACTIVE;
            r_bit_cnt   <= 3'd0;
            r_rx_shift  <= 7'd0;
            r_byte_done <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (w_cs_rise) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_rx_shift  <= 7'd0;
            r_byte_done <= 1'b0;
          end else if (w_lead) begin
            r_rx_shift <= w_rx_byte[6:0];
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_rx_data   <= w_rx_byte;
              r_rx_valid  <= 1'b1;
              r_byte_done <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Load priority: a full holding register is never written in the
  // cycle it is transferred because o_tx_ready is already low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_shift  <= 8'd0;
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_wr) begin
        r_hold      <= i_tx_data;
        r_hold_full <= 1'b1;
      end
      if (w_load) begin
        if (r_hold_full) begin
          r_tx_shift  <= r_hold;
          r_hold_full <= 1'b0;
        end else begin
          r_tx_shift <= 8'd0;
          r_underrun <= 1'b1;
        end
      end else if (w_abort) begin
        r_tx_shift <= 8'd0;
      end else if (w_shift_out) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
    end
  end

  assign o_miso        = w_active & r_tx_shift[7];
  assign o_miso_oe     = w_active;
  assign o_busy        = w_active;
  assign o_tx_ready    = ~r_hold_full;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_tx_underrun = r_underrun;

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: a CPOL=0 and a CPOL=1 instance driven by a
// bit-level SPI controller model, checked against a scoreboard of queues.
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sclk;
  logic [1:0] cs_n;
  logic       mosi;
  logic [7:0] tx_data;
  logic [1:0] tx_valid;
  logic [1:0] miso;
  logic [1:0] miso_oe;
  logic [1:0] tx_ready;
  logic [1:0] rx_valid;
  logic [1:0] underrun;
  logic [1:0] busy;
  logic [7:0] rx_data0;
  logic [7:0] rx_data1;

  int n_vec = 0;
  int n_err = 0;
  int rx_cnt = 0;
  int ur_cnt = 0;
  int ur_at_rx = -1;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  logic [15:0] mi;
  logic [15:0] mi2;

  always #5 clk = ~clk;

  spi_peripheral #(.CPOL(1'b0)) u_m0 (
    .i_clk(clk), .i_rst(rst), .i_sclk(sclk[0]), .i_cs_n(cs_n[0]),
    .i_mosi(mosi), .o_miso(miso[0]), .o_miso_oe(miso_oe[0]),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid[0]),
    .o_tx_ready(tx_ready[0]), .o_rx_data(rx_data0),
    .o_rx_valid(rx_valid[0]), .o_tx_underrun(underrun[0]),
    .o_busy(busy[0])
  );

  spi_peripheral #(.CPOL(1'b1)) u_m1 (
    .i_clk(clk), .i_rst(rst), .i_sclk(sclk[1]), .i_cs_n(cs_n[1]),
    .i_mosi(mosi), .o_miso(miso[1]), .o_miso_oe(miso_oe[1]),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid[1]),
    .o_tx_ready(tx_ready[1]), .o_rx_data(rx_data1),
    .o_rx_valid(rx_valid[1]), .o_tx_underrun(underrun[1]),
    .o_busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rx_valid[m] === 1'b1) begin
        rx_cnt++;
        if (exp_rx.size() > 0)
          check($sformatf("rx_data%0d", m),
                (m == 1) ? rx_data1 : rx_data0, exp_rx.pop_front());
      end
      if (underrun[m] === 1'b1) begin
        ur_cnt++;
        ur_at_rx = rx_cnt;
      end
    end
  end

  task automatic clear_sb();
    rx_cnt = 0;
    ur_cnt = 0;
    ur_at_rx = -1;
    exp_rx.delete();
    exp_miso.delete();
  endtask

  task automatic tx_push(input int m, input logic [7:0] d);
    int t;
    t = 0;
    while (tx_ready[m] !== 1'b1 && t < 200) begin
      wait_clk(1);
      t++;
    end
    check($sformatf("tx_ready_wait%0d", m), tx_ready[m], 1);
    tx_data = d;
    tx_valid[m] = 1'b1;
    wait_clk(1);
    tx_valid[m] = 1'b0;
    check($sformatf("tx_ready_full%0d", m), tx_ready[m], 0);
    exp_miso.push_back(d);
  endtask

  // Frame ends after the last leading edge; SCLK returns to idle only
  // once CS_N is high, so those edges must be ignored.
  task automatic run_frame(input int m, input int nbits,
                           input logic [15:0] mo,
                           output logic [15:0] mo_cap);
    logic idle;
    idle = (m == 1);
    mo_cap = '0;
    mosi = mo[15];
    cs_n[m] = 1'b0;
    wait_clk(8);
    check($sformatf("busy_on%0d", m), busy[m], 1);
    check($sformatf("oe_on%0d", m), miso_oe[m], 1);
    for (int b = 0; b < nbits; b++) begin
      mosi = mo[15-b];
      wait_clk(4);
      mo_cap = {mo_cap[14:0], miso[m]};
      sclk[m] = ~idle;
      wait_clk(4);
      if (b != nbits - 1)
        sclk[m] = idle;
    end
    cs_n[m] = 1'b1;
    wait_clk(4);
    sclk[m] = idle;
    wait_clk(8);
    check($sformatf("busy_off%0d", m), busy[m], 0);
    check($sformatf("oe_off%0d", m), miso_oe[m], 0);
    check($sformatf("miso_off%0d", m), miso[m], 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sclk = 2'b10;
    cs_n = 2'b11;
    mosi = 1'b0;
    tx_data = 8'h00;
    tx_valid = 2'b00;
    wait_clk(4);
    check("rst_busy", busy, 2'b00);
    check("rst_oe", miso_oe, 2'b00);
    check("rst_miso", miso, 2'b00);
    check("rst_ready", tx_ready, 2'b11);
    check("rst_rxv", rx_valid, 2'b00);
    check("rst_ur", underrun, 2'b00);
    check("rst_rxd0", rx_data0, 8'h00);
    check("rst_rxd1", rx_data1, 8'h00);
    rst = 1'b0;
    wait_clk(6);

    // single byte, mode 0
    clear_sb();
    tx_push(0, 8'hA5);
    exp_rx.push_back(8'h3C);
    run_frame(0, 8, 16'h3C00, mi);
    check("s1_miso", mi[7:0], exp_miso.pop_front());
    check("s1_rxcnt", rx_cnt, 1);
    check("s1_ur", ur_cnt, 0);
    check("s1_drain", exp_rx.size(), 0);

    // back-to-back bytes, second written once ready rises
    clear_sb();
    tx_push(0, 8'h12);
    exp_rx.push_back(8'hF0);
    exp_rx.push_back(8'h0F);
    fork
      run_frame(0, 16, 16'hF00F, mi);
      tx_push(0, 8'h34);
    join
    check("b2b_miso0", mi[15:8], exp_miso.pop_front());
    check("b2b_miso1", mi[7:0], exp_miso.pop_front());
    check("b2b_rxcnt", rx_cnt, 2);
    check("b2b_ur", ur_cnt, 0);
    check("b2b_drain", exp_rx.size(), 0);

    // underrun at the second byte
    clear_sb();
    tx_push(0, 8'h81);
    exp_miso.push_back(8'h00);
    exp_rx.push_back(8'hAA);
    exp_rx.push_back(8'h55);
    run_frame(0, 16, 16'hAA55, mi);
    check("ur_miso0", mi[15:8], exp_miso.pop_front());
    check("ur_miso1", mi[7:0], exp_miso.pop_front());
    check("ur_cnt", ur_cnt, 1);
    check("ur_where", ur_at_rx, 1);
    check("ur_rxcnt", rx_cnt, 2);

    // abort after 5 bits; byte in holding register survives
    clear_sb();
    tx_push(0, 8'h5A);
    fork
      run_frame(0, 5, 16'hFFFF, mi);
      tx_push(0, 8'h77);
    join
    mi2 = {8'h00, exp_miso.pop_front()};
    check("ab_miso", mi[4:0], mi2[7:3]);
    check("ab_rxcnt", rx_cnt, 0);
    check("ab_ur", ur_cnt, 0);
    check("ab_hold", tx_ready[0], 0);
    exp_rx.push_back(8'h55);
    run_frame(0, 8, 16'h5500, mi);
    check("ab2_miso", mi[7:0], exp_miso.pop_front());
    check("ab2_rxcnt", rx_cnt, 1);
    check("ab2_ur", ur_cnt, 0);
    check("ab2_rxd", rx_data0, 8'h55);

    // reset mid-frame, then stale frame ignored, then a clean frame
    clear_sb();
    tx_push(0, 8'hC3);
    exp_miso.delete();
    cs_n[0] = 1'b0;
    mosi = 1'b1;
    wait_clk(8);
    for (int b = 0; b < 3; b++) begin
      wait_clk(4);
      sclk[0] = 1'b1;
      wait_clk(4);
      sclk[0] = 1'b0;
    end
    rst = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    check("mr_busy", busy[0], 0);
    check("mr_oe", miso_oe[0], 0);
    check("mr_miso", miso[0], 0);
    check("mr_ready", tx_ready[0], 1);
    check("mr_rxd", rx_data0, 8'h00);
    check("mr_rxv", rx_valid[0], 0);
    check("mr_ur", underrun[0], 0);
    for (int b = 0; b < 8; b++) begin
      wait_clk(4);
      sclk[0] = 1'b1;
      wait_clk(4);
      sclk[0] = 1'b0;
    end
    check("mr_stale_busy", busy[0], 0);
    cs_n[0] = 1'b1;
    wait_clk(8);
    check("mr_stale_rx", rx_cnt, 0);
    check("mr_stale_ur", ur_cnt, 0);
    exp_rx.push_back(8'h96);
    exp_miso.push_back(8'h00);
    run_frame(0, 8, 16'h9600, mi);
    check("mr_miso", mi[7:0], exp_miso.pop_front());
    check("mr_rxcnt", rx_cnt, 1);
    check("mr_urcnt", ur_cnt, 1);

    // CPOL=1 instance, single byte
    clear_sb();
    check("p1_oe_pre", miso_oe[1], 0);
    tx_push(1, 8'hA5);
    exp_rx.push_back(8'h3C);
    run_frame(1, 8, 16'h3C00, mi);
    check("p1_miso", mi[7:0], exp_miso.pop_front());
    check("p1_rxcnt", rx_cnt, 1);
    check("p1_ur", ur_cnt, 0);
    check("p1_other", busy[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
